am_constant_serial_loader: RTL and testbench
============================================

Name: am_constant_serial_loader

Overview:
- Host-side writer for the 16-bit AM constant load register. Receives a framed serial word from the control MCU (CS_N/SCLK/SDI, mode 0, MSB first) and deserializes it.
- Presents the word with a one-cycle load strobe, in the (data, EN) form the constant register's load port expects.
- Sits between the MCU pins and the AM constant register. Rejects malformed or stalled frames so a bad transfer never disturbs the running constant.

Parameters:
DATA_W, 16, word width in bits; frame length is exactly DATA_W SCLK rising edges.
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on CS_N, SCLK and SDI (minimum 2).
TIMEOUT, 1023, maximum number of Clock cycles allowed between SCLK rising edges inside a frame before the frame is aborted.

Ports:
Clock  input  1  system clock; all logic on its rising edge.
Reset  input  1  synchronous, active-high reset.
CS_N  input  1  host frame select, active low, asynchronous to Clock.
SCLK  input  1  host serial clock, asynchronous to Clock.
SDI  input  1  host serial data, sampled on synchronized SCLK rising edge.
Dout  output  DATA_W  last accepted word, held between frames.
EN  output  1  one-cycle load strobe, valid together with the new Dout.
Busy  output  1  high while a frame is in progress or being resolved (state != IDLE).
FrameErr  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (Clock edge with Reset=1): Dout=0, EN=0, Busy=0, FrameErr=0, state=IDLE, bit counter=0, shift register=0, timeout counter=0. Synchronizer flops reset to idle levels: CS_N=1, SCLK=0, SDI=0.
- Reset mid-frame aborts the frame with no EN and no FrameErr. After Reset deasserts, if CS_N is still low, the FSM waits in IDLE for CS_N high before accepting a new frame (no partial frame).
- All three inputs pass through SYNC_STAGES flops. Edge detection uses one more registered copy of synchronized SCLK and CS_N.
- Host timing requirement: SCLK high and low each last at least SYNC_STAGES+1 Clock periods.
- States:
  - IDLE: a CS_N falling edge goes to SHIFT. Clear the bit counter, shift register and timeout counter.
  - SHIFT:
    - On each SCLK rising edge, shift register <= {shift[DATA_W-2:0], SDI_sync}, bit counter += 1, and the timeout counter clears.
    - The bit counter saturates at DATA_W+1, which marks overflow.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT, go to ERR.
    - On a CS_N rising edge: count == DATA_W goes to LOAD; any other count goes to ERR.
    - A CS_N rising edge and an SCLK rising edge in the same Clock cycle: the SCLK edge is ignored. The count check uses the count before that edge.
  - LOAD: Dout <= shift register and EN=1 for exactly this one cycle. Next state IDLE.
  - ERR: FrameErr=1 for the single cycle of entry. Dout unchanged, EN stays 0. Remain in ERR until CS_N sync is high, then go to IDLE.
- Latency: EN asserts SYNC_STAGES+2 Clock rising edges after the first edge that samples CS_N high at the pin.
- Dout changes only in the cycle EN=1.
- Back-to-back frames: a new CS_N falling edge is accepted in the first IDLE cycle after LOAD or ERR. No minimum gap beyond synchronizer latency.
- SCLK edges while CS_N is high are ignored.
- SDI is sampled from the same synchronizer stage depth as SCLK, so relative alignment is preserved.

Test Plan:
- Reset: hold Reset=1 for 3 cycles with CS_N=0 and toggling SCLK -> Dout=0x0000, EN=0, Busy=0, FrameErr=0. After release, no EN until CS_N goes high and a new frame starts.
- Nominal frame: send 0xA5C3 MSB first (16 SCLK edges), raise CS_N -> exactly one EN pulse with Dout=0xA5C3, EN at CS_N-rise + SYNC_STAGES+2 cycles. Busy high from CS_N-fall+SYNC_STAGES+1 cycles until the cycle after EN. FrameErr stays 0.
- Short/long frames: 15 edges carrying 0x1234, then 17 edges carrying 0xFFFF (previous Dout=0xA5C3) -> a FrameErr pulse for each frame, no EN, Dout stays 0xA5C3.
- Timeout: 8 SCLK edges, then SCLK idle for TIMEOUT+5 cycles with CS_N low -> FrameErr pulse at cycle TIMEOUT after the last edge, Busy stays high until CS_N rises. A following good frame of 0x0001 gives EN with Dout=0x0001.
- Back-to-back: frames 0x0000, 0xFFFF, 0x8001 with minimal CS_N-high gap (SYNC_STAGES+2 cycles) -> three EN pulses with Dout 0x0000, 0xFFFF, 0x8001 in order, no FrameErr.
- Boundary edge: the 16th SCLK edge coincides with CS_N rise at the synchronizer output -> FrameErr (count was 15), no EN.

Source files
------------

// File: rtl/am_constant_serial_loader.sv
// -----------------------------------------------------------------------------
// am_constant_serial_loader
//
// Host-side writer for the 16-bit AM constant load register. Deserializes a
// framed mode-0 word (CS_N / SCLK / SDI, MSB first) from the control MCU and
// hands it to the constant register as a (Dout, EN) pair. Frames with the
// wrong bit count, or that stall for TIMEOUT Clock cycles between SCLK rising
// edges, are rejected with a FrameErr pulse, so the running constant is left
// alone.
//
// Ports
//   Clock     system clock, all logic on its rising edge
//   Reset     synchronous, active-high reset
//   CS_N      host frame select, active low, asynchronous to Clock
//   SCLK      host serial clock, asynchronous to Clock
//   SDI       host serial data, captured on synchronized SCLK rising edges
//   Dout      last accepted word, held between frames
//   EN        one-cycle load strobe, valid together with the new Dout
//   Busy      high while a frame is in progress or being resolved
//   FrameErr  one-cycle pulse when a frame is rejected
// -----------------------------------------------------------------------------
module am_constant_serial_loader #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              CS_N,
   input  logic              SCLK,
   input  logic              SDI,
   output logic [DATA_W-1:0] Dout,
   output logic              EN,
   output logic              Busy,
   output logic              FrameErr
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(DATA_W + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD,
      ERR
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;
   logic [SYNC_STAGES-1:0] settle;
   logic                   cs_s;
   logic                   sclk_s;
   logic                   sdi_s;
   logic                   cs_prev;
   logic                   sclk_prev;
   logic                   sdi_prev;
   logic                   armed;
   logic                   cs_fall;
   logic                   cs_rise_q;
   logic                   sclk_rise_q;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign sdi_s  = sdi_sync[SYNC_STAGES-1];

   // NOTE: every clocked process uses non-blocking assignments so all flops
   // sample the values from before the edge; blocking here would collapse the
   // synchronizer chain into a single stage.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         // NOTE: synchronizer flops reset to the idle line levels (CS_N high,
         // SCLK and SDI low) rather than being left unreset, so the edge
         // detectors see no spurious edge coming out of reset.
         cs_sync     <= '1;
         sclk_sync   <= '0;
         sdi_sync    <= '0;
         settle      <= '0;
         cs_prev     <= 1'b1;
         sclk_prev   <= 1'b0;
         sdi_prev    <= 1'b0;
         armed       <= 1'b0;
         cs_rise_q   <= 1'b0;
         sclk_rise_q <= 1'b0;
      end else begin
         cs_sync     <= {cs_sync[SYNC_STAGES-2:0], CS_N};
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], SDI};
         settle      <= {settle[SYNC_STAGES-2:0], 1'b1};
         cs_prev     <= cs_s;
         sclk_prev   <= sclk_s;
         sdi_prev    <= sdi_s;
         // Until a genuine CS_N-high level has come through the synchronizer
         // after reset, a low CS_N belongs to a frame that was cut by reset.
         armed       <= armed | (settle[SYNC_STAGES-1] & cs_s);
         // In-frame events are registered as a pair so a coincident SCLK and
         // CS_N rise always reach the FSM in the same cycle; sdi_prev is the
         // SDI copy aligned with the registered SCLK edge.
         cs_rise_q   <= cs_s & ~cs_prev;
         sclk_rise_q <= sclk_s & ~sclk_prev;
      end
   end

   assign cs_fall = armed & cs_prev & ~cs_s;

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_next;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_next;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [TMO_W-1:0]  tmo_next;

   // NOTE: every signal driven here gets a default before the case statement;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift_q;
      tmo_next     = tmo_cnt;

      unique case (state)
         IDLE: begin
            bit_cnt_next = '0;
            shift_next   = '0;
            tmo_next     = '0;
            if (cs_fall) begin
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            // CS_N rise wins over a coincident SCLK rise: the count is judged
            // as it stood before that last SCLK edge.
            if (cs_rise_q) begin
               state_next = (bit_cnt == CNT_FULL) ? LOAD : ERR;
            end else if (sclk_rise_q) begin
               shift_next = {shift_q[DATA_W-2:0], sdi_prev};
               if (bit_cnt != CNT_OVF) begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
               tmo_next = '0;
            end else begin
               tmo_next = tmo_cnt + 1'b1;
               if (tmo_next == TMO_MAX) begin
                  state_next = ERR;
               end
            end
         end

         LOAD: begin
            state_next = IDLE;
         end

         ERR: begin
            if (cs_s) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shift_q  <= '0;
         tmo_cnt  <= '0;
         Dout     <= '0;
         FrameErr <= 1'b0;
      end else begin
         state    <= state_next;
         bit_cnt  <= bit_cnt_next;
         shift_q  <= shift_next;
         tmo_cnt  <= tmo_next;
         // Dout is updated on the edge into LOAD so it is valid with EN.
         if (state_next == LOAD) begin
            Dout <= shift_q;
         end
         FrameErr <= (state_next == ERR) && (state != ERR);
      end
   end

   assign EN   = (state == LOAD);
   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_am_constant_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_am_constant_serial_loader
//
// Self-checking bench for am_constant_serial_loader. Every frame the bench
// drives pushes the event it must produce (a load with a word, or a frame
// error) onto a scoreboard queue; a negedge monitor pops and compares each
// EN / FrameErr pulse. Scenario tasks add timing and hold checks inline.
// -----------------------------------------------------------------------------
module tb_am_constant_serial_loader;

   localparam int DATA_W      = 16;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 1023;
   localparam int HALF_SCLK   = SYNC_STAGES + 2;

   logic              Clock;
   logic              Reset;
   logic              CS_N;
   logic              SCLK;
   logic              SDI;
   logic [DATA_W-1:0] Dout;
   logic              EN;
   logic              Busy;
   logic              FrameErr;

   am_constant_serial_loader #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .CS_N     (CS_N),
      .SCLK     (SCLK),
      .SDI      (SDI),
      .Dout     (Dout),
      .EN       (EN),
      .Busy     (Busy),
      .FrameErr (FrameErr)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef enum logic {EV_LOAD, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t          kind;
      logic [DATA_W-1:0] data;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev;

   int tests_run    = 0;
   int tests_failed = 0;

   int cycle = 0;
   int fall_cycle;
   int rise_cycle;
   int sclk_rise_cycle;
   int en_cycle;
   int err_cycle;
   int busy_rise_cycle;
   int busy_fall_cycle;
   int busy_rises = 0;
   int en_total   = 0;
   logic busy_prev = 1'b0;
   logic busy_at_en;

   always @(posedge Clock) cycle <= cycle + 1;

   // Scoreboard monitor: outputs change on posedge, sampled on negedge.
   always @(negedge Clock) begin
      if (Busy === 1'b1 && !busy_prev) begin
         busy_rise_cycle = cycle;
         busy_rises++;
      end
      if (Busy !== 1'b1 && busy_prev) begin
         busy_fall_cycle = cycle;
      end
      busy_prev = (Busy === 1'b1);
      if (EN === 1'b1) begin
         en_cycle   = cycle;
         busy_at_en = Busy;
         en_total++;
      end
      if (FrameErr === 1'b1) begin
         err_cycle = cycle;
      end
      if (EN === 1'b1 || FrameErr === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_event: got EN=%0b FrameErr=%0b Dout=%h, required no event",
                     EN, FrameErr, Dout);
         end else begin
            ev = exp_q.pop_front();
            if (ev.kind == EV_LOAD) begin
               if (EN !== 1'b1 || FrameErr !== 1'b0 || Dout !== ev.data) begin
                  tests_failed++;
                  $display("FAIL load_event: got EN=%0b FrameErr=%0b Dout=%h, required EN=1 FrameErr=0 Dout=%h",
                           EN, FrameErr, Dout, ev.data);
               end
            end else if (EN !== 1'b0 || FrameErr !== 1'b1) begin
               tests_failed++;
               $display("FAIL err_event: got EN=%0b FrameErr=%0b, required EN=0 FrameErr=1",
                        EN, FrameErr);
            end
         end
      end
   end

   task automatic expect_event(input ev_kind_t kind, input logic [DATA_W-1:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) until every expected event has been seen.
   task automatic wait_drain(output int left);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Clock);
      repeat (4) @(negedge Clock);
      left = exp_q.size();
   endtask

   task automatic sclk_bit(input logic b);
      SDI = b;
      repeat (HALF_SCLK) @(negedge Clock);
      SCLK            = 1'b1;
      sclk_rise_cycle = cycle;
      repeat (HALF_SCLK) @(negedge Clock);
      SCLK = 1'b0;
   endtask

   // Drives one frame of nbits edges, MSB (bit nbits-1) first; ends with CS_N high.
   task automatic send_frame(input logic [31:0] word, input int nbits);
      CS_N       = 1'b0;
      fall_cycle = cycle;
      repeat (HALF_SCLK) @(negedge Clock);
      for (int i = nbits - 1; i >= 0; i--) sclk_bit(word[i]);
      repeat (HALF_SCLK) @(negedge Clock);
      CS_N       = 1'b1;
      rise_cycle = cycle;
   endtask

   task automatic test_reset;
      int rises_before;
      int left;
      Reset = 1'b1;
      CS_N  = 1'b0;
      SCLK  = 1'b0;
      SDI   = 1'b1;
      repeat (3) begin
         @(negedge Clock);
         SCLK = ~SCLK;
      end
      tests_run += 4;
      if (Dout !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_dout: got %h, required 0000", Dout);
      end
      if (EN !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_en: got %b, required 0", EN);
      end
      if (Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b, required 0", Busy);
      end
      if (FrameErr !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_frameerr: got %b, required 0", FrameErr);
      end
      // Release with CS_N still low: the leftover frame must be ignored.
      rises_before = busy_rises;
      Reset        = 1'b0;
      SCLK         = 1'b0;
      for (int i = 0; i < 20; i++) sclk_bit(i[0]);
      CS_N = 1'b1;
      // SCLK activity with CS_N high is ignored as well.
      for (int i = 0; i < 3; i++) sclk_bit(1'b1);
      wait_drain(left);
      tests_run++;
      if (busy_rises !== rises_before) begin
         tests_failed++;
         $display("FAIL reset_no_frame: got %0d Busy rises, required 0", busy_rises - rises_before);
      end
   endtask

   task automatic test_reset_mid_frame;
      int rises_before;
      int left;
      logic [15:0] w;
      w    = 16'h5A5A;
      CS_N = 1'b0;
      repeat (HALF_SCLK) @(negedge Clock);
      for (int i = 15; i >= 11; i--) sclk_bit(w[i]);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      tests_run++;
      if (Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_busy: got %b, required 0", Busy);
      end
      rises_before = busy_rises;
      for (int i = 10; i >= 0; i--) sclk_bit(w[i]);
      repeat (HALF_SCLK) @(negedge Clock);
      CS_N = 1'b1;
      wait_drain(left);
      tests_run++;
      if (busy_rises !== rises_before) begin
         tests_failed++;
         $display("FAIL midreset_partial_frame: got %0d Busy rises, required 0", busy_rises - rises_before);
      end
   endtask

   task automatic test_nominal;
      int left;
      int en_before;
      en_before = en_total;
      expect_event(EV_LOAD, 16'hA5C3);
      send_frame(32'h0000_A5C3, 16);
      wait_drain(left);
      tests_run += 6;
      if (left !== 0) begin
         tests_failed++;
         $display("FAIL nominal_drain: got %0d events missing, required 0", left);
      end
      if (en_total - en_before !== 1) begin
         tests_failed++;
         $display("FAIL nominal_en_count: got %0d, required 1", en_total - en_before);
      end
      if (en_cycle - rise_cycle !== SYNC_STAGES + 2) begin
         tests_failed++;
         $display("FAIL nominal_en_latency: got %0d, required %0d", en_cycle - rise_cycle, SYNC_STAGES + 2);
      end
      if (busy_rise_cycle - fall_cycle !== SYNC_STAGES + 1) begin
         tests_failed++;
         $display("FAIL nominal_busy_rise: got %0d, required %0d", busy_rise_cycle - fall_cycle, SYNC_STAGES + 1);
      end
      if (busy_at_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL nominal_busy_at_en: got %b, required 1", busy_at_en);
      end
      if (busy_fall_cycle - en_cycle !== 1) begin
         tests_failed++;
         $display("FAIL nominal_busy_fall: got %0d, required 1", busy_fall_cycle - en_cycle);
      end
   endtask

   task automatic test_short_long;
      int left;
      expect_event(EV_ERR, '0);
      send_frame(32'h0000_1234, 15);
      repeat (8) @(negedge Clock);
      expect_event(EV_ERR, '0);
      send_frame(32'h0001_FFFF, 17);
      wait_drain(left);
      tests_run += 2;
      if (left !== 0) begin
         tests_failed++;
         $display("FAIL short_long_drain: got %0d events missing, required 0", left);
      end
      if (Dout !== 16'hA5C3) begin
         tests_failed++;
         $display("FAIL short_long_dout_hold: got %h, required a5c3", Dout);
      end
   endtask

   task automatic test_timeout;
      int left;
      logic [7:0] b;
      b = 8'hC6;
      expect_event(EV_ERR, '0);
      CS_N = 1'b0;
      repeat (HALF_SCLK) @(negedge Clock);
      for (int i = 7; i >= 0; i--) sclk_bit(b[i]);
      repeat (TIMEOUT + 5) @(negedge Clock);
      tests_run += 3;
      if (exp_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL timeout_err_seen: got %0d events missing, required 0", exp_q.size());
      end
      if (err_cycle - sclk_rise_cycle !== TIMEOUT + SYNC_STAGES + 2) begin
         tests_failed++;
         $display("FAIL timeout_latency: got %0d, required %0d", err_cycle - sclk_rise_cycle,
                  TIMEOUT + SYNC_STAGES + 2);
      end
      if (Busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_busy_held: got %b, required 1", Busy);
      end
      CS_N = 1'b1;
      repeat (6) @(negedge Clock);
      tests_run++;
      if (Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_busy_release: got %b, required 0", Busy);
      end
      expect_event(EV_LOAD, 16'h0001);
      send_frame(32'h0000_0001, 16);
      wait_drain(left);
      tests_run += 2;
      if (left !== 0) begin
         tests_failed++;
         $display("FAIL timeout_recover_drain: got %0d events missing, required 0", left);
      end
      if (Dout !== 16'h0001) begin
         tests_failed++;
         $display("FAIL timeout_recover_dout: got %h, required 0001", Dout);
      end
   endtask

   task automatic test_back_to_back;
      int left;
      int en_before;
      logic [15:0] words [3];
      words[0]  = 16'h0000;
      words[1]  = 16'hFFFF;
      words[2]  = 16'h8001;
      en_before = en_total;
      for (int f = 0; f < 3; f++) begin
         expect_event(EV_LOAD, words[f]);
         send_frame({16'h0000, words[f]}, 16);
         repeat (SYNC_STAGES + 2) @(negedge Clock);
      end
      wait_drain(left);
      tests_run += 3;
      if (left !== 0) begin
         tests_failed++;
         $display("FAIL b2b_drain: got %0d events missing, required 0", left);
      end
      if (en_total - en_before !== 3) begin
         tests_failed++;
         $display("FAIL b2b_en_count: got %0d, required 3", en_total - en_before);
      end
      if (Dout !== 16'h8001) begin
         tests_failed++;
         $display("FAIL b2b_final_dout: got %h, required 8001", Dout);
      end
   endtask

   task automatic test_boundary;
      int left;
      logic [15:0] w;
      w = 16'h3C3C;
      expect_event(EV_ERR, '0);
      CS_N = 1'b0;
      repeat (HALF_SCLK) @(negedge Clock);
      for (int i = 15; i >= 1; i--) sclk_bit(w[i]);
      // 16th SCLK rise lands together with the CS_N rise.
      SDI = w[0];
      repeat (HALF_SCLK) @(negedge Clock);
      SCLK = 1'b1;
      CS_N = 1'b1;
      repeat (HALF_SCLK) @(negedge Clock);
      SCLK = 1'b0;
      wait_drain(left);
      tests_run += 2;
      if (left !== 0) begin
         tests_failed++;
         $display("FAIL boundary_drain: got %0d events missing, required 0", left);
      end
      if (Dout !== 16'h8001) begin
         tests_failed++;
         $display("FAIL boundary_dout_hold: got %h, required 8001", Dout);
      end
   endtask

   initial begin
      Reset = 1'b1;
      CS_N  = 1'b0;
      SCLK  = 1'b0;
      SDI   = 1'b0;
      test_reset();
      test_reset_mid_frame();
      test_nominal();
      test_short_long();
      test_timeout();
      test_back_to_back();
      test_boundary();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
